// File: rtl/cic_decim_ctrl_if.sv
// Configuration handshake for cic_decim_ctrl.
//   cfg_rate  : requested decimation rate (CW bits)
//   cfg_valid : request, held by the requester until accepted
//   cfg_ready : controller accepts; transfer when cfg_valid & cfg_ready
//   cfg_err   : one-cycle pulse after a transfer that carried rate 0
interface cic_decim_ctrl_if #(
   parameter int unsigned CW = 8
) ();
   logic [CW-1:0] cfg_rate;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          cfg_err;

   modport master (
      output cfg_rate,
      output cfg_valid,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_rate,
      input  cfg_valid,
      output cfg_ready,
      output cfg_err
   );
endinterface

// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for a CIC decimator.
// Produces the integrator enable for every accepted sample, the comb enable once per R
// samples, and an output-valid strobe aligned to the comb-chain latency. The rate is
// programmable through the cfg interface and only changes at a decimation boundary; after
// any (re)start the output stays off until N boundaries have refilled the comb memory.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_enable       : run enable
//   i_ready        : input-sample strobe
//   cfg            : rate configuration handshake (slave side)
//   o_integ_en     : integrator-chain enable
//   o_comb_en      : comb-chain enable (decimated strobe)
//   o_ready        : decimated output valid
//   o_phase        : current input-sample phase, 0..R-1
//   o_rate         : active rate
//   o_settled      : high once the comb memory is refilled
module cic_decim_ctrl #(
   parameter int unsigned CW        = 8,
   parameter int unsigned N         = 3,
   parameter int unsigned COMB_LAT  = 3,
   parameter int unsigned R_DEFAULT = 5
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_enable,
   input  logic                i_ready,
   cic_decim_ctrl_if.slave     cfg,
   output logic                o_integ_en,
   output logic                o_comb_en,
   output logic                o_ready,
   output logic [CW-1:0]       o_phase,
   output logic [CW-1:0]       o_rate,
   output logic                o_settled
);

   localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StSettle, StRun} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         phase_q, phase_d;
   logic [CW-1:0]         rate_q, rate_d;
   logic [SW-1:0]         settle_q, settle_d;
   logic                  cfg_err_q, cfg_err_d;
   logic                  integ_q;
   logic                  bnd_q, bnd_qual_q;
   logic                  comb_q, comb_qual_q;
   logic [COMB_LAT-1:0]   dly_q, dly_d;

   logic                  accept, boundary, qual, cfg_rdy, xfer, phase_last;

   assign phase_last = (phase_q == rate_q - CW'(1));

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      rate_d    = rate_q;
      settle_d  = settle_q;
      cfg_err_d = 1'b0;
      cfg_rdy   = 1'b0;
      accept    = 1'b0;
      boundary  = 1'b0;
      qual      = 1'b0;
      xfer      = 1'b0;

      case (state_q)
         StIdle: begin
            cfg_rdy = 1'b1;
            phase_d = '0;
            if (i_enable) begin
               state_d  = StSettle;
               settle_d = '0;
            end
         end
         StSettle, StRun: begin
            if (!i_enable) begin
               // A would-be boundary is dropped along with the sample.
               state_d = StIdle;
               phase_d = '0;
            end else if (i_ready) begin
               accept = 1'b1;
               if (phase_last) begin
                  boundary = 1'b1;
                  cfg_rdy  = 1'b1;
                  phase_d  = '0;
                  qual     = (state_q == StRun);
                  if (state_q == StSettle) begin
                     if (settle_q == SW'(N - 1)) begin
                        state_d = StRun;
                     end else begin
                        settle_d = settle_q + SW'(1);
                     end
                  end
               end else begin
                  phase_d = phase_q + CW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Rate change overrides the settle progress computed above; the boundary's own
      // comb strobe and qualifier are unaffected.
      xfer = cfg.cfg_valid & cfg_rdy;
      if (xfer) begin
         if (cfg.cfg_rate == '0) begin
            cfg_err_d = 1'b1;
         end else begin
            rate_d = cfg.cfg_rate;
            if (state_q != StIdle) begin
               state_d  = StSettle;
               settle_d = '0;
               phase_d  = '0;
            end
         end
      end
   end

   always_comb begin
      dly_d    = '0;
      dly_d[0] = comb_q & comb_qual_q;
      for (int i = 1; i < COMB_LAT; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         phase_q     <= '0;
         rate_q      <= CW'(R_DEFAULT);
         settle_q    <= '0;
         cfg_err_q   <= 1'b0;
         integ_q     <= 1'b0;
         bnd_q       <= 1'b0;
         bnd_qual_q  <= 1'b0;
         comb_q      <= 1'b0;
         comb_qual_q <= 1'b0;
         dly_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         rate_q      <= rate_d;
         settle_q    <= settle_d;
         cfg_err_q   <= cfg_err_d;
         integ_q     <= accept;
         // Extra stage so the comb runs after the integrator has absorbed the R-th sample.
         bnd_q       <= boundary;
         bnd_qual_q  <= qual;
         comb_q      <= bnd_q;
         comb_qual_q <= bnd_qual_q;
         dly_q       <= dly_d;
      end
   end

   assign cfg.cfg_ready = cfg_rdy;
   assign cfg.cfg_err   = cfg_err_q;
   assign o_integ_en    = integ_q;
   assign o_comb_en     = comb_q;
   assign o_ready       = dly_q[COMB_LAT-1];
   assign o_phase       = phase_q;
   assign o_rate        = rate_q;
   assign o_settled     = (state_q == StRun);

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Sequencing controller for the CIC decimation path. It generates the integrator-stage enable on every accepted input sample and the comb-stage enable once every R samples. It also produces an output-valid strobe aligned to the comb-chain latency. The decimation rate R is runtime-programmable through a valid/ready config port; rate changes take effect only at a decimation boundary, and the output is held off until the comb memory has refilled.

Parameters:
CW, 8, width of rate register and phase counter; legal R = 1..2^CW-1
N, 3, number of CIC stages; sets the settle count in decimated strobes
COMB_LAT, 3, comb-chain pipeline latency in cycles from o_comb_en to valid comb output (>=1)
R_DEFAULT, 5, rate loaded at reset

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_enable  in  1  run enable
i_ready  in  1  input-sample strobe from upstream
i_cfg_rate  in  CW  requested decimation rate
i_cfg_valid  in  1  config request; held until accepted
o_cfg_ready  out  1  config accept; transfer when i_cfg_valid & o_cfg_ready
o_cfg_err  out  1  one-cycle pulse: accepted rate was 0, rejected
o_integ_en  out  1  integrator-chain enable
o_comb_en  out  1  comb-chain enable (decimated strobe)
o_ready  out  1  decimated output valid, aligned to comb output
o_phase  out  CW  current input-sample phase, 0..R-1
o_rate  out  CW  active rate
o_settled  out  1  high in RUN

Behaviour:
- Clocking and reset: one clock i_clk. i_rst_n sampled on the rising edge only.
- Reset values: state IDLE, o_rate=R_DEFAULT, phase=0, settle_cnt=0, COMB_LAT delay line cleared. All other outputs 0.
- States: IDLE, SETTLE, RUN.
- IDLE:
  - o_integ_en=0, no boundaries, o_cfg_ready=1 (combinational on state).
  - Config transfer: o_rate <= i_cfg_rate next cycle.
  - i_cfg_rate==0: o_rate unchanged, o_cfg_err pulses next cycle, and the handshake still completes.
  - i_enable=1: state SETTLE next cycle, phase=0, settle_cnt=0.
- SETTLE/RUN, while i_enable=1:
  - Accepted sample: i_ready=1.
  - Each accepted sample: phase <= phase+1, or 0 if phase==o_rate-1.
  - Boundary at cycle t: accepted sample with phase==o_rate-1.
  - o_integ_en(t+1) = sample accepted at t.
  - o_comb_en(t+2) = boundary at t. This sequences the comb after the integrator update of the R-th sample.
  - R=1: every sample is a boundary.
- Settle:
  - In SETTLE, each boundary increments settle_cnt; the N-th boundary moves state to RUN at t+1.
  - Boundaries occurring in SETTLE are unqualified. Boundaries in RUN are qualified.
  - The qualifier bit travels with o_comb_en through the COMB_LAT delay line.
  - o_ready = o_comb_en of a qualified boundary delayed COMB_LAT cycles, i.e. cycle t+2+COMB_LAT.
- Rate change in SETTLE/RUN:
  - o_cfg_ready=1 only in a boundary cycle.
  - On transfer at that boundary: the boundary still produces its o_comb_en and qualifier as normal.
  - o_rate updated next cycle, phase=0, state SETTLE, settle_cnt=0.
  - Rate 0 in SETTLE/RUN: rejected per IDLE rule, state unchanged.
  - i_cfg_valid without a boundary: it waits; no partial effect.
- i_enable=0 in SETTLE/RUN:
  - i_ready ignored that cycle, including a would-be boundary.
  - State IDLE next cycle, phase=0.
  - Strobes already in flight (o_integ_en, o_comb_en, delay line) complete and drain normally.
- Phase counter: compare with o_rate-1 at full CW width. If o_rate is lowered, phase never exceeds the new rate-1, because the change applies at a boundary with phase reset.
- o_phase reflects the registered phase. o_settled = (state==RUN).
- Synchronous reset mid-operation: all state, pipeline and delay-line bits cleared in the same edge. No strobe emerges afterwards.

Test Plan:
- Defaults, reset released, i_enable=1 at cycle 0, i_ready=1 from cycle 1 → boundaries at 5/10/15/20, o_comb_en at 7/12/17/22, o_settled from 16, first o_ready at cycle 25, then every 5 cycles; o_integ_en continuous from cycle 2.
- R=2 set in IDLE, i_ready every 3rd cycle → o_comb_en every 6 cycles; o_phase toggles 0/1; o_ready only from the 4th o_comb_en, COMB_LAT later.
- RUN at R=5, i_cfg_valid=1 with rate 4 mid-frame → o_cfg_ready pulses only at the next boundary; that strobe still yields o_ready; next 3 strobes at R=4 suppressed; o_ready resumes on the 4th.
- IDLE, i_cfg_rate=0 with i_cfg_valid=1 → o_cfg_err one-cycle pulse, o_rate stays 5; repeat with rate 1 in RUN → o_comb_en on every sample after re-settle.
- RUN, boundary at t, i_enable dropped at t+1 → o_comb_en at t+2 and o_ready at t+5 still appear; o_integ_en 0 from t+2; state IDLE.
- i_rst_n=0 one cycle while o_ready is in flight → next cycle all outputs 0, o_rate=5, no delayed o_ready ever emerges.
